hazard_unit: RTL

Pipeline hazard controller that drives the stall and branch-squash controls consumed by the ID/EX pipeline register, and the matching hold/flush controls for the IF and ID stages. It keeps a shadow copy of the destination-register state for the instructions in EX and MEM. It detects load-use RAW hazards and, with forwarding disabled, all RAW hazards. It sequences the post-branch bubbles and counts stall and flush events for performance monitoring. It sits beside the ID stage and is fed by the decoder and the EX-stage branch unit.

---
 rtl/hazard_unit_pkg.sv | 34 +++
 rtl/hazard_unit_sat_counter.sv | 23 ++
 rtl/hazard_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   state_t  : hazard FSM states (RUN, FLUSH)
//   REG_W    : register-index width
//   shadow_t : shadow copy of a pipeline slot {rd, we, load}
//   src_hit  : true when an ID source register reads a pending destination
package hazard_unit_pkg;

   localparam int REG_W = 5;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             we;
      logic             load;
   } shadow_t;

   // x0 is hard-wired to zero, so writing it never creates a dependency.
   function automatic logic src_hit(
      input logic [REG_W-1:0] rs1,
      input logic             rs1_used,
      input logic [REG_W-1:0] rs2,
      input logic             rs2_used,
      input logic [REG_W-1:0] rd,
      input logic             we
   );
      return we && (rd != '0) &&
             ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter.
//   clk   : rising-edge clock
//   clear : synchronous clear, wins over inc
//   inc   : count one event this cycle
//   cnt   : current count, holds at all-ones instead of wrapping
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller sitting beside the ID stage.
// Tracks the destinations of the instructions in EX and MEM, stalls on
// load-use (or any RAW when forwarding is absent), squashes the slots after
// a taken branch and counts stall / flush events.
//   clk, rst                 : clock, synchronous active-high reset
//   d_valid, d_rs1, d_rs2,
//   d_rs1_used, d_rs2_used,
//   d_rd, d_we, d_load       : decoded ID-stage instruction
//   e_taken                  : EX resolved a taken branch/jump this cycle
//   pc_hold, d_hold, d_flush : IF / IF-ID controls
//   stall, jb                : ID/EX controls (stall=1 bubble, jb=0 squash)
//   stall_cnt, flush_cnt     : saturating performance counters
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter bit FWD          = 1'b1,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_valid,
   input  logic [REG_W-1:0] d_rs1,
   input  logic [REG_W-1:0] d_rs2,
   input  logic             d_rs1_used,
   input  logic             d_rs2_used,
   input  logic [REG_W-1:0] d_rd,
   input  logic             d_we,
   input  logic             d_load,
   input  logic             e_taken,
   output logic             pc_hold,
   output logic             d_hold,
   output logic             d_flush,
   output logic             stall,
   output logic             jb,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);

   state_t           state;
   logic [1:0]       remaining;
   shadow_t          e_sh;
   logic [REG_W-1:0] m_rd;
   logic             m_we;

   logic match_e;
   logic match_m;
   logic hz;
   logic id_issue;

   assign match_e = src_hit(d_rs1, d_rs1_used, d_rs2, d_rs2_used, e_sh.rd, e_sh.we);
   assign match_m = src_hit(d_rs1, d_rs1_used, d_rs2, d_rs2_used, m_rd, m_we);

   // With forwarding only a load in EX is too late; without it any pending
   // write in EX or MEM must drain first.
   assign hz = FWD ? (d_valid && match_e && e_sh.load)
                   : (d_valid && (match_e || match_m));

   // Branch squash outranks the hazard: the stalled ID instruction is
   // discarded anyway, so no hold is raised.
   always_comb begin
      pc_hold = 1'b0;
      d_hold  = 1'b0;
      d_flush = 1'b0;
      stall   = 1'b0;
      jb      = 1'b1;
      if (rst) begin
         stall   = 1'b1;
         jb      = 1'b0;
         pc_hold = 1'b1;
         d_flush = 1'b1;
      end else if (e_taken || (state == FLUSH)) begin
         jb      = 1'b0;
         d_flush = 1'b1;
      end else if (hz) begin
         stall   = 1'b1;
         pc_hold = 1'b1;
         d_hold  = 1'b1;
      end
   end

   // The ID/EX register takes the ID instruction only when neither a bubble
   // nor a squash is being loaded.
   assign id_issue = d_valid && !stall && jb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         remaining <= '0;
         e_sh      <= '0;
         m_rd      <= '0;
         m_we      <= 1'b0;
      end else begin
         m_rd <= e_sh.rd;
         m_we <= e_sh.we;
         if (id_issue) begin
            e_sh.rd   <= d_rd;
            e_sh.we   <= d_we;
            e_sh.load <= d_load;
         end else begin
            e_sh <= '0;
         end

         case (state)
            RUN: begin
               if (e_taken && (FLUSH_CYCLES > 1)) begin
                  state     <= FLUSH;
                  remaining <= RELOAD;
               end
            end
            FLUSH: begin
               if (e_taken) begin
                  remaining <= RELOAD;
               end else begin
                  remaining <= remaining - 2'd1;
                  if (remaining == 2'd1) begin
                     state <= RUN;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (stall),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (e_taken),
      .cnt   (flush_cnt)
   );

endmodule
